// File: rtl/mips_cpu_hilo_div_pkg.sv
// Shared definitions for the HI/LO divide unit: request codes, control states
// and the request-to-result latencies seen at the hi/lo outputs.
package mips_cpu_hilo_div_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_DIV  = 3'd1,
      OP_DIVU = 3'd2,
      OP_MTHI = 3'd3,
      OP_MTLO = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_WAIT  = 2'd2,
      ST_FIX   = 2'd3
   } state_e;

   // Rising edges from the accepting edge to the hi/lo update.
   localparam int DIV_LAT      = 34;
   localparam int DIV_LAT_ZERO = 3;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
   function automatic logic [31:0] mag32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mips_cpu_divideru.sv
// Unsigned iterative restoring divider, one quotient bit per clock.
// The first bit is produced on the start edge, so a nonzero dividend finishes
// 32 edges after start is sampled; a zero dividend finishes on the start edge.
// done stays high until the next start.
module mips_cpu_divideru (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o,
   output logic        done_o,
   output logic        dbz_o
);

   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        run_q, run_d;
   logic        done_q, done_d;
   logic        dbz_q, dbz_d;
   logic [63:0] step;

   // One restoring step: shift the next dividend bit in, subtract if it fits.
   function automatic logic [63:0] div_step(input logic [31:0] r,
                                            input logic [31:0] q,
                                            input logic [31:0] d);
      logic [32:0] sh;
      logic [32:0] diff;
      sh   = {r, q[31]};
      diff = sh - {1'b0, d};
      if (sh >= {1'b0, d}) return {diff[31:0], q[30:0], 1'b1};
      else                 return {sh[31:0], q[30:0], 1'b0};
   endfunction

   // Next-state: load and first step on start, then iterate until the count expires.
   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = done_q;
      dbz_d  = dbz_q;
      step   = 64'd0;
      if (start_i) begin
         dvs_d  = divisor_i;
         dbz_d  = (divisor_i == 32'd0);
         done_d = 1'b0;
         if (dividend_i == 32'd0) begin
            rem_d  = 32'd0;
            quo_d  = 32'd0;
            run_d  = 1'b0;
            done_d = 1'b1;
         end else begin
            step           = div_step(32'd0, dividend_i, divisor_i);
            {rem_d, quo_d} = step;
            cnt_d          = 6'd31;
            run_d          = 1'b1;
         end
      end else if (run_q) begin
         step           = div_step(rem_q, quo_q, dvs_q);
         {rem_d, quo_d} = step;
         cnt_d          = cnt_q - 6'd1;
         if (cnt_q == 6'd1) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   // State registers; reset abandons any divide in progress.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rem_q  <= 32'd0;
         quo_q  <= 32'd0;
         dvs_q  <= 32'd0;
         cnt_q  <= 6'd0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
         dbz_q  <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
         dbz_q  <= dbz_d;
      end
   end

   assign quotient_o  = quo_q;
   assign remainder_o = rem_q;
   assign done_o      = done_q;
   assign dbz_o       = dbz_q;

endmodule

// File: rtl/mips_cpu_hilo_div.sv
// HI/LO register pair with a multi-cycle signed/unsigned divide.
// Signed divides run on magnitudes in the unsigned divider; signs are
// reapplied in FIX. MTHI/MTLO and divide-by-zero complete in one edge.
module mips_cpu_hilo_div
   import mips_cpu_hilo_div_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        op_valid,
   input  logic [2:0]  op_code,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        dbz
);

   state_e      state_q, state_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        dbz_q, dbz_d;
   logic [31:0] mag_a_q, mag_a_d;
   logic [31:0] mag_b_q, mag_b_d;
   logic        neg_q_q, neg_q_d;
   logic        neg_r_q, neg_r_d;

   logic [31:0] div_quo;
   logic [31:0] div_rem;
   logic        div_done;
   logic        div_dbz_unused;
   logic        div_start;

   assign div_start = (state_q == ST_START);

   mips_cpu_divideru u_divu (
      .clk_i       (clk),
      .rst_i       (~reset_n),
      .start_i     (div_start),
      .dividend_i  (mag_a_q),
      .divisor_i   (mag_b_q),
      .quotient_o  (div_quo),
      .remainder_o (div_rem),
      .done_o      (div_done),
      .dbz_o       (div_dbz_unused)
   );

   // Request decode and divide sequencing. START leaves unconditionally, so a
   // done left over from the previous divide is never acted on.
   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dbz_d   = dbz_q;
      mag_a_d = mag_a_q;
      mag_b_d = mag_b_q;
      neg_q_d = neg_q_q;
      neg_r_d = neg_r_q;
      case (state_q)
         ST_IDLE: begin
            if (op_valid) begin
               case (op_code)
                  OP_MTHI: hi_d = op_a;
                  OP_MTLO: lo_d = op_a;
                  OP_DIV, OP_DIVU: begin
                     if (op_b == 32'd0) begin
                        dbz_d = 1'b1;
                     end else begin
                        dbz_d   = 1'b0;
                        state_d = ST_START;
                        if (op_code == OP_DIV) begin
                           mag_a_d = mag32(op_a);
                           mag_b_d = mag32(op_b);
                           neg_q_d = op_a[31] ^ op_b[31];
                           neg_r_d = op_a[31];
                        end else begin
                           mag_a_d = op_a;
                           mag_b_d = op_b;
                           neg_q_d = 1'b0;
                           neg_r_d = 1'b0;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_START: state_d = ST_WAIT;
         ST_WAIT:  if (div_done) state_d = ST_FIX;
         ST_FIX: begin
            lo_d    = neg_q_q ? (32'd0 - div_quo) : div_quo;
            hi_d    = neg_r_q ? (32'd0 - div_rem) : div_rem;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Architectural and control registers, cleared immediately by reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         dbz_q   <= 1'b0;
         mag_a_q <= 32'd0;
         mag_b_q <= 32'd0;
         neg_q_q <= 1'b0;
         neg_r_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dbz_q   <= dbz_d;
         mag_a_q <= mag_a_d;
         mag_b_q <= mag_b_d;
         neg_q_q <= neg_q_d;
         neg_r_q <= neg_r_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign dbz  = dbz_q;

endmodule

// File: tb/tb_mips_cpu_hilo_div.sv
// Bench for mips_cpu_hilo_div: a cycle-level reference model derived from the
// request/latency rules, compared every cycle, plus literal result checks.
module tb_mips_cpu_hilo_div;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        op_valid = 1'b0;
   logic [2:0]  op_code = 3'd0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        dbz;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mips_cpu_hilo_div dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .op_valid (op_valid),
      .op_code  (op_code),
      .op_a     (op_a),
      .op_b     (op_b),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .dbz      (dbz)
   );

   // Reference model: remaining edges until the pending result lands.
   int          m_cnt = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
   logic        m_dbz = 1'b0;

   always @(posedge clk or negedge reset_n) begin
      longint x, y, qq, rr;
      if (!reset_n) begin
         m_cnt = 0; m_hi = 32'd0; m_lo = 32'd0; m_dbz = 1'b0;
      end else if (m_cnt > 0) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            m_hi = p_hi;
            m_lo = p_lo;
         end
      end else if (op_valid) begin
         if (op_code == 3'd3) m_hi = op_a;
         else if (op_code == 3'd4) m_lo = op_a;
         else if (op_code == 3'd1 || op_code == 3'd2) begin
            if (op_b == 32'd0) begin
               m_dbz = 1'b1;
            end else begin
               if (op_code == 3'd1) begin
                  x = longint'($signed(op_a));
                  y = longint'($signed(op_b));
               end else begin
                  x = longint'({32'd0, op_a});
                  y = longint'({32'd0, op_b});
               end
               qq = x / y;       // truncating division, remainder takes dividend sign
               rr = x % y;
               p_lo  = qq[31:0];
               p_hi  = rr[31:0];
               m_dbz = 1'b0;
               m_cnt = (op_a == 32'd0) ? 3 : 34;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("busy", {31'd0, busy}, {31'd0, (m_cnt > 0)});
         check("hi",   hi, m_hi);
         check("lo",   lo, m_lo);
         check("dbz",  {31'd0, dbz}, {31'd0, m_dbz});
      end
   end

   // Drive one request for one cycle; call at a negedge or just after a posedge.
   task automatic issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      op_valid = 1'b1; op_code = c; op_a = a; op_b = b;
      @(posedge clk); #1;
      op_valid = 1'b0; op_code = 3'd0;
   endtask

   // Count negedges with busy high; bounded.
   task automatic wait_idle(output int n);
      n = 0;
      forever begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (n > 100) begin
            check("idle_timeout", 32'd1, 32'd0);
            break;
         end
      end
   endtask

   int n;

   initial begin
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      check("rst_dbz", {31'd0, dbz}, 32'd0);

      // first request on the first edge after release
      reset_n = 1'b1;
      issue(3'd4, 32'h1234_5678, 32'd0);
      check("first_mtlo", lo, 32'h1234_5678);

      // DIVU 100/7
      @(negedge clk);
      issue(3'd2, 32'd100, 32'd7);
      wait_idle(n);
      check("divu_lat", n, 32'd34);
      check("divu_lo", lo, 32'd14);
      check("divu_hi", hi, 32'd2);
      check("divu_dbz", {31'd0, dbz}, 32'd0);

      // back-to-back: accepted on the edge right after busy fell
      issue(3'd1, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      check("div_m7_2_lo", lo, 32'hFFFF_FFFD);
      check("div_m7_2_hi", hi, 32'hFFFF_FFFF);

      issue(3'd1, 32'd7, 32'hFFFF_FFFE);
      wait_idle(n);
      check("div_7_m2_lo", lo, 32'hFFFF_FFFD);
      check("div_7_m2_hi", hi, 32'd1);

      // MTHI then divide by zero
      issue(3'd3, 32'hDEAD_BEEF, 32'd0);
      issue(3'd1, 32'd5, 32'd0);
      check("dbz_busy", {31'd0, busy}, 32'd0);
      check("dbz_flag", {31'd0, dbz}, 32'd1);
      check("dbz_hi", hi, 32'hDEAD_BEEF);
      check("dbz_lo", lo, 32'hFFFF_FFFD);

      // most negative / -1
      @(negedge clk);
      issue(3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      check("ovf_lo", lo, 32'h8000_0000);
      check("ovf_hi", hi, 32'd0);
      check("ovf_dbz", {31'd0, dbz}, 32'd0);

      // zero dividend
      issue(3'd2, 32'd0, 32'd5);
      wait_idle(n);
      check("zero_lat", n, 32'd3);
      check("zero_lo", lo, 32'd0);
      check("zero_hi", hi, 32'd0);

      // MTLO while busy is ignored
      issue(3'd2, 32'd50, 32'd5);
      repeat (4) @(posedge clk);
      #1;
      issue(3'd4, 32'h0000_AAAA, 32'd0);
      wait_idle(n);
      check("mtlo_busy_lo", lo, 32'd10);
      check("mtlo_busy_hi", hi, 32'd0);

      // reset at edge 10 of a divide
      issue(3'd3, 32'h0000_0011, 32'd0);
      @(negedge clk);
      issue(3'd2, 32'd1000, 32'd3);
      repeat (9) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      check("midrst_dbz", {31'd0, dbz}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (40) @(negedge clk);
      check("postrst_lo", lo, 32'd0);
      check("postrst_hi", hi, 32'd0);
      issue(3'd2, 32'd9, 32'd3);
      wait_idle(n);
      check("after_rst_lo", lo, 32'd3);
      check("after_rst_hi", hi, 32'd0);

      // op_code 5 is a NOP
      issue(3'd5, 32'h5555_5555, 32'd1);
      @(negedge clk);
      check("nop5_busy", {31'd0, busy}, 32'd0);
      check("nop5_lo", lo, 32'd3);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
